// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: writes each accepted sample into a circular delay line in
// the sample RAM, then reads NumTaps samples back, newest to oldest, and hands
// them to the MAC with a tap index and a last-tap flag.
module fir_tap_sequencer #(
   parameter int unsigned DataWidth = 18,
   parameter int unsigned AddrWidth = 7,
   parameter int unsigned NumTaps   = 64,
   parameter int unsigned IdxWidth  = (NumTaps > 1) ? $clog2(NumTaps) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [DataWidth-1:0] in_data_i,
   output logic                 ram_wen_o,
   output logic [AddrWidth-1:0] ram_wr_addr_o,
   output logic [DataWidth-1:0] ram_data_o,
   output logic                 ram_ren_o,
   output logic [AddrWidth-1:0] ram_rd_addr_o,
   input  logic [DataWidth-1:0] ram_data_i,
   output logic                 tap_valid_o,
   output logic [DataWidth-1:0] tap_data_o,
   output logic [IdxWidth-1:0]  tap_idx_o,
   output logic                 tap_last_o,
   output logic                 busy_o
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRead = 1'b1;

   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumTaps - 1);

   logic [0:0]           state_q, state_d;
   logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrWidth-1:0] last_ptr_q, last_ptr_d;
   logic [IdxWidth-1:0]  rd_cnt_q, rd_cnt_d;
   logic                 tap_valid_q;
   logic [IdxWidth-1:0]  tap_idx_q;
   logic                 tap_last_q;

   // Ready and busy are pure decodes of the state register.
   assign in_ready_o = (state_q == StIdle);
   assign busy_o     = (state_q == StRead);

   // State, pointer and read-counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         last_ptr_q <= '0;
         rd_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         last_ptr_q <= last_ptr_d;
         rd_cnt_q   <= rd_cnt_d;
      end
   end

   // Next-state logic plus the RAM write/read strobes for the current cycle.
   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      last_ptr_d    = last_ptr_q;
      rd_cnt_d      = rd_cnt_q;
      ram_wen_o     = 1'b0;
      ram_wr_addr_o = '0;
      ram_data_o    = '0;
      ram_ren_o     = 1'b0;
      ram_rd_addr_o = '0;
      case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               ram_wen_o     = 1'b1;
               ram_wr_addr_o = wr_ptr_q;
               ram_data_o    = in_data_i;
               last_ptr_d    = wr_ptr_q;
               wr_ptr_d      = wr_ptr_q + AddrWidth'(1);
               rd_cnt_d      = '0;
               state_d       = StRead;
            end
         end
         StRead: begin
            ram_ren_o     = 1'b1;
            // Walk backwards from the newest sample, wrapping below address 0.
            ram_rd_addr_o = last_ptr_q - AddrWidth'(rd_cnt_q);
            if (rd_cnt_q == LastIdx) begin
               rd_cnt_d = '0;
               state_d  = StIdle;
            end else begin
               rd_cnt_d = rd_cnt_q + IdxWidth'(1);
            end
         end
      endcase
   end

   // Tap qualifiers trail the read strobe by the RAM's one-cycle latency.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tap_valid_q <= 1'b0;
         tap_idx_q   <= '0;
         tap_last_q  <= 1'b0;
      end else begin
         tap_valid_q <= ram_ren_o;
         tap_idx_q   <= ram_ren_o ? rd_cnt_q : '0;
         tap_last_q  <= ram_ren_o && (rd_cnt_q == LastIdx);
      end
   end

   assign tap_valid_o = tap_valid_q;
   assign tap_idx_o   = tap_idx_q;
   assign tap_last_o  = tap_last_q;
   assign tap_data_o  = ram_data_i;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: behavioural sample RAM, expected-tap scoreboard
// filled on every accept and drained by a tap monitor.
module tb_fir_tap_sequencer;

   localparam int unsigned DW    = 18;
   localparam int unsigned AW    = 7;
   localparam int unsigned NT    = 4;
   localparam int unsigned IW    = 2;
   localparam int unsigned Depth = 128;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [IW-1:0] idx;
      logic          last;
   } tap_t;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b1;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [DW-1:0] in_data_i = '0;
   logic          ram_wen_o;
   logic [AW-1:0] ram_wr_addr_o;
   logic [DW-1:0] ram_data_o;
   logic          ram_ren_o;
   logic [AW-1:0] ram_rd_addr_o;
   logic [DW-1:0] ram_data_i;
   logic          tap_valid_o;
   logic [DW-1:0] tap_data_o;
   logic [IW-1:0] tap_idx_o;
   logic          tap_last_o;
   logic          busy_o;

   int checks = 0;
   int failures = 0;

   tap_t          exp_q[$];
   logic [DW-1:0] model_mem [Depth] = '{default: '0};
   logic [AW-1:0] model_wp = '0;

   logic          obs_wen;
   logic [AW-1:0] obs_waddr;
   logic [DW-1:0] obs_wdata;

   always #5 clk_i = ~clk_i;

   fir_tap_sequencer #(
      .DataWidth(DW),
      .AddrWidth(AW),
      .NumTaps  (NT),
      .IdxWidth (IW)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .in_data_i    (in_data_i),
      .ram_wen_o    (ram_wen_o),
      .ram_wr_addr_o(ram_wr_addr_o),
      .ram_data_o   (ram_data_o),
      .ram_ren_o    (ram_ren_o),
      .ram_rd_addr_o(ram_rd_addr_o),
      .ram_data_i   (ram_data_i),
      .tap_valid_o  (tap_valid_o),
      .tap_data_o   (tap_data_o),
      .tap_idx_o    (tap_idx_o),
      .tap_last_o   (tap_last_o),
      .busy_o       (busy_o)
   );

   // Sample RAM with registered read data; contents survive reset.
   logic [DW-1:0] ram_mem [Depth] = '{default: '0};
   always @(posedge clk_i) begin
      if (ram_wen_o) ram_mem[ram_wr_addr_o] <= ram_data_o;
   end
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)        ram_data_i <= '0;
      else if (ram_ren_o) ram_data_i <= ram_mem[ram_rd_addr_o];
   end

   // Reference delay line: record the sample and queue its NT expected taps.
   function automatic void model_accept(input logic [DW-1:0] d);
      logic [AW-1:0] a;
      tap_t t;
      model_mem[model_wp] = d;
      for (int k = 0; k < int'(NT); k++) begin
         a      = model_wp - AW'(k);
         t.data = model_mem[a];
         t.idx  = IW'(k);
         t.last = (k == int'(NT) - 1);
         exp_q.push_back(t);
      end
      model_wp = model_wp + AW'(1);
   endfunction

   // Tap monitor: compare every valid tap against the scoreboard head.
   always @(negedge clk_i) begin : tap_monitor
      tap_t e;
      if (rst_ni) begin
         checks++;
         if (tap_valid_o) begin
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL tap_unexpected: got data=%0d idx=%0d last=%0d, none expected",
                        tap_data_o, tap_idx_o, tap_last_o);
            end else begin
               e = exp_q.pop_front();
               if (tap_data_o !== e.data || tap_idx_o !== e.idx || tap_last_o !== e.last) begin
                  failures++;
                  $display("FAIL tap: got data=%0d idx=%0d last=%0d, want data=%0d idx=%0d last=%0d",
                           tap_data_o, tap_idx_o, tap_last_o, e.data, e.idx, e.last);
               end
            end
         end else if (tap_idx_o !== '0 || tap_last_o !== 1'b0) begin
            failures++;
            $display("FAIL tap_idle: got idx=%0d last=%0d, want 0 0", tap_idx_o, tap_last_o);
         end
      end
   end

   task automatic do_reset();
      in_valid_i = 1'b0;
      rst_ni     = 1'b0;
      exp_q.delete();
      model_wp   = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      #2 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   // Present a sample until accepted; record the write strobe seen at acceptance.
   task automatic send(input logic [DW-1:0] d);
      bit ok = 0;
      in_valid_i = 1'b1;
      in_data_i  = d;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (in_ready_o) begin
            ok        = 1;
            obs_wen   = ram_wen_o;
            obs_waddr = ram_wr_addr_o;
            obs_wdata = ram_data_o;
            model_accept(d);
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: sample %0d never accepted", d);
      end
      @(posedge clk_i);
      #1 in_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (exp_q.size() == 0 && in_ready_o) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL drain: %0d taps still pending, in_ready=%0d", exp_q.size(), in_ready_o);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      #2 rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if ({in_ready_o, busy_o, ram_wen_o, ram_ren_o, tap_valid_o, tap_last_o} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_ctrl_in_reset: got %b, want 100000",
                  {in_ready_o, busy_o, ram_wen_o, ram_ren_o, tap_valid_o, tap_last_o});
      end
      @(negedge clk_i);
      #2 rst_ni = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if ({in_ready_o, busy_o, ram_wen_o, ram_ren_o, tap_valid_o, tap_last_o} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b, want 100000",
                  {in_ready_o, busy_o, ram_wen_o, ram_ren_o, tap_valid_o, tap_last_o});
      end
      checks++;
      if ({ram_wr_addr_o, ram_data_o, ram_rd_addr_o, tap_data_o, tap_idx_o} !== '0) begin
         failures++;
         $display("FAIL reset_data: got waddr=%0d wdata=%0d raddr=%0d tap=%0d idx=%0d, want all 0",
                  ram_wr_addr_o, ram_data_o, ram_rd_addr_o, tap_data_o, tap_idx_o);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_single();
      logic [AW-1:0] exp_a [4];
      exp_a = '{7'd0, 7'd127, 7'd126, 7'd125};
      do_reset();
      send(18'd5);
      checks++;
      if (obs_wen !== 1'b1 || obs_waddr !== 7'd0 || obs_wdata !== 18'd5) begin
         failures++;
         $display("FAIL single_write: got wen=%0d addr=%0d data=%0d, want 1 0 5",
                  obs_wen, obs_waddr, obs_wdata);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         checks++;
         if (ram_ren_o !== 1'b1 || busy_o !== 1'b1 || in_ready_o !== 1'b0 ||
             ram_wen_o !== 1'b0 || ram_rd_addr_o !== exp_a[i]) begin
            failures++;
            $display("FAIL single_read%0d: got ren=%0d busy=%0d rdy=%0d wen=%0d addr=%0d, want 1 1 0 0 %0d",
                     i, ram_ren_o, busy_o, in_ready_o, ram_wen_o, ram_rd_addr_o, exp_a[i]);
         end
         @(posedge clk_i);
         #1;
      end
      @(negedge clk_i);
      checks++;
      if (in_ready_o !== 1'b1 || busy_o !== 1'b0 || ram_ren_o !== 1'b0 || tap_last_o !== 1'b1) begin
         failures++;
         $display("FAIL single_end: got rdy=%0d busy=%0d ren=%0d last=%0d, want 1 0 0 1",
                  in_ready_o, busy_o, ram_ren_o, tap_last_o);
      end
      @(posedge clk_i);
      #1;
      wait_idle();
   endtask

   task automatic test_three();
      do_reset();
      send(18'd1);
      send(18'd2);
      send(18'd3);
      checks++;
      if (obs_waddr !== 7'd2 || obs_wdata !== 18'd3) begin
         failures++;
         $display("FAIL three_write: got addr=%0d data=%0d, want 2 3", obs_waddr, obs_wdata);
      end
      wait_idle();
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_a [4];
      exp_a = '{7'd1, 7'd0, 7'd127, 7'd126};
      do_reset();
      for (int i = 0; i < 129; i++) send(DW'(i));
      send(18'd129);
      checks++;
      if (obs_wen !== 1'b1 || obs_waddr !== 7'd1) begin
         failures++;
         $display("FAIL wrap_write: got wen=%0d addr=%0d, want 1 1", obs_wen, obs_waddr);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         checks++;
         if (ram_rd_addr_o !== exp_a[i]) begin
            failures++;
            $display("FAIL wrap_read%0d: got addr=%0d, want %0d", i, ram_rd_addr_o, exp_a[i]);
         end
         @(posedge clk_i);
         #1;
      end
      wait_idle();
      send(18'd130);
      checks++;
      if (obs_waddr !== 7'd2) begin
         failures++;
         $display("FAIL wrap_ptr: got addr=%0d, want 2", obs_waddr);
      end
      wait_idle();
   endtask

   task automatic test_back_to_back();
      logic exp_wen, exp_tv, exp_rdy;
      do_reset();
      in_valid_i = 1'b1;
      in_data_i  = 18'd10;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk_i);
         exp_wen = (c == 0 || c == 5);
         exp_rdy = (c == 0 || c == 5 || c == 10);
         exp_tv  = (c >= 2 && c <= 5) || (c >= 7 && c <= 10);
         checks++;
         if ({ram_wen_o, in_ready_o, tap_valid_o} !== {exp_wen, exp_rdy, exp_tv}) begin
            failures++;
            $display("FAIL b2b_c%0d: got wen=%0d rdy=%0d tv=%0d, want %0d %0d %0d",
                     c, ram_wen_o, in_ready_o, tap_valid_o, exp_wen, exp_rdy, exp_tv);
         end
         if (c == 0) model_accept(18'd10);
         if (c == 5) begin
            model_accept(18'd11);
            checks++;
            if (ram_data_o !== 18'd11 || ram_wr_addr_o !== 7'd1) begin
               failures++;
               $display("FAIL b2b_second: got data=%0d addr=%0d, want 11 1", ram_data_o, ram_wr_addr_o);
            end
         end
         @(posedge clk_i);
         #1;
         if (c == 0) in_data_i = 18'd11;
         if (c == 5) in_valid_i = 1'b0;
      end
      wait_idle();
   endtask

   task automatic test_reset_mid_read();
      bit ok = 0;
      do_reset();
      send(18'd9);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         if (tap_valid_o && tap_idx_o == 2'd1) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL midrst_wait: tap idx 1 never seen");
      end
      #2 rst_ni = 1'b0;
      exp_q.delete();
      model_wp = '0;
      #1;
      checks++;
      if ({in_ready_o, busy_o, ram_wen_o, ram_ren_o, tap_valid_o, tap_last_o} !== 6'b100000 ||
          tap_idx_o !== '0 || ram_rd_addr_o !== '0 || tap_data_o !== '0) begin
         failures++;
         $display("FAIL midrst_outputs: got ctrl=%b idx=%0d raddr=%0d tap=%0d, want 100000 0 0 0",
                  {in_ready_o, busy_o, ram_wen_o, ram_ren_o, tap_valid_o, tap_last_o},
                  tap_idx_o, ram_rd_addr_o, tap_data_o);
      end
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      #2 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      send(18'd7);
      checks++;
      if (obs_wen !== 1'b1 || obs_waddr !== 7'd0 || obs_wdata !== 18'd7) begin
         failures++;
         $display("FAIL midrst_write: got wen=%0d addr=%0d data=%0d, want 1 0 7",
                  obs_wen, obs_waddr, obs_wdata);
      end
      wait_idle();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      test_reset();
      test_single();
      test_three();
      test_wrap();
      test_back_to_back();
      test_reset_mid_read();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover: %0d taps never observed", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Initiator-side controller for the filter sample RAM.
- Accepts one input sample per valid/ready handshake and writes it into the RAM as a circular delay line.
- Then issues NumTaps reads, newest to oldest, and presents each returned sample to the downstream MAC with tap index and last-tap flag.
- Sits between the sample stream source and the sample RAM/MAC datapath.

Parameters:
DataWidth, 18, sample width in bits (signed two's complement, passed through unmodified)
AddrWidth, 7, RAM address width; delay-line depth = 2**AddrWidth
NumTaps, 64, reads per sample; legal range 1..2**AddrWidth
IdxWidth, max(1, $clog2(NumTaps)), derived width of tap index

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
in_valid_i  in  1  input sample valid
in_ready_o  out  1  block can accept a sample
in_data_i  in  DataWidth  input sample
ram_wen_o  out  1  RAM write enable
ram_wr_addr_o  out  AddrWidth  RAM write address
ram_data_o  out  DataWidth  RAM write data
ram_ren_o  out  1  RAM read enable
ram_rd_addr_o  out  AddrWidth  RAM read address
ram_data_i  in  DataWidth  RAM registered read data (1-cycle latency after ren)
tap_valid_o  out  1  tap_data_o holds a valid tap sample
tap_data_o  out  DataWidth  tap sample (equals ram_data_i)
tap_idx_o  out  IdxWidth  tap index, 0 = newest sample
tap_last_o  out  1  high with tap_idx_o = NumTaps-1
busy_o  out  1  read sequence in progress

Behaviour:
- Reset values: FSM = IDLE, wr_ptr = 0, rd_cnt = 0. in_ready_o = 1. All other outputs = 0.
- FSM states: IDLE and READ.
- in_ready_o:
  - High exactly when the FSM is in IDLE.
  - Registered-state decode only; it must not depend combinationally on in_valid_i.
- Accept: in_valid_i & in_ready_o in cycle T.
  - Combinationally in cycle T: ram_wen_o = 1, ram_wr_addr_o = wr_ptr, ram_data_o = in_data_i.
  - At the edge ending cycle T: last_ptr <= wr_ptr; wr_ptr <= wr_ptr + 1 (mod 2**AddrWidth, natural wrap); FSM -> READ; rd_cnt <= 0.
  - ram_wen_o = 0 in every other cycle.
- READ, each cycle:
  - ram_ren_o = 1.
  - ram_rd_addr_o = last_ptr - rd_cnt (mod 2**AddrWidth, wrapping below 0).
  - rd_cnt increments by 1.
  - When rd_cnt = NumTaps-1, the FSM returns to IDLE at the end of that cycle.
- READ lasts exactly NumTaps cycles. busy_o = 1 in READ. ram_ren_o = 0 in IDLE.
- Read-after-write: the first read (cycle T+1) targets the address written at the end of cycle T and must return the new sample. The RAM write occurs at that edge, so no bypass is required.
- Tap output: registered copies of ren and rd_cnt, delayed 1 cycle.
  - tap_valid_o(t) = ram_ren_o(t-1); tap_idx_o(t) = rd_cnt(t-1).
  - tap_last_o(t) = ram_ren_o(t-1) & (rd_cnt(t-1) = NumTaps-1).
  - tap_data_o = ram_data_i, combinational pass-through.
  - When tap_valid_o = 0: tap_idx_o = 0 and tap_last_o = 0.
- Latency: accept in cycle T gives tap 0 in cycle T+2 and the last tap in cycle T+NumTaps+1.
- Taps are contiguous with no gaps. There is no backpressure on the tap output; the MAC always accepts.
- Throughput:
  - Next accept is possible in cycle T+NumTaps+1 (the IDLE cycle that carries the last tap).
  - Back-to-back sustained rate: 1 sample per NumTaps+1 cycles.
  - The write in that cycle goes to wr_ptr, never the address being returned, so there is no hazard.
- Holding input: if in_valid_i = 1 while in READ, the sample is not consumed. The source holds it until accepted.
- NumTaps = 1: READ lasts 1 cycle; tap_last_o = 1 with tap_idx_o = 0.
- NumTaps = 2**AddrWidth: the last read returns the sample written 2**AddrWidth-1 accepts earlier.
- Unwritten locations read as RAM reset contents (0).
- Async reset mid-operation: all state and outputs return to reset values immediately. wr_ptr = 0, so the next accepted sample is written to address 0. A partial tap sequence is abandoned with no tap_last_o.

Test Plan:
- Reset: hold rst_ni low, release -> in_ready_o = 1, busy_o = 0, ram_wen_o = ram_ren_o = tap_valid_o = 0, all data/addr outputs 0.
- NumTaps = 4, single sample 5 accepted in cycle 0:
  - ram_wen_o = 1, ram_wr_addr_o = 0 in cycle 0.
  - ram_rd_addr_o = 0,127,126,125 in cycles 1-4.
  - taps 5,0,0,0 with idx 0..3 in cycles 2-5; tap_last_o only in cycle 5; in_ready_o = 1 from cycle 5.
- NumTaps = 4, samples 1,2,3 -> after third accept, taps 3,2,1,0 with idx 0..3.
- Wrap-around, NumTaps = 4: feed samples with value = index 0..129 -> 130th write at address 1, wr_ptr = 2; reads at 1,0,127,126 return 129,128,127,126.
- Backpressure: in_valid_i held high with sequence 10,11 -> 11 held while busy_o = 1, accepted exactly NumTaps+1 cycles after 10; tap stream continuous; no sample lost or duplicated.
- Reset mid-READ: pulse rst_ni low after tap idx 1 -> outputs 0 immediately, no tap_last_o; next sample 7 is written at address 0 and returned as tap 0.
